// File: rtl/uart_pkg.sv
// Shared frame constants and transmitter state encoding for the UART link.
// The receiver imports this package as well.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 8;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// bit_tick_next marks the cycle before bit_tick so the caller can register a pulse for the terminal cycle.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_tick,
  output logic bit_tick_next
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear on request, wrap at the terminal count.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (bit_tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_tick      = (count_q == CNT_LAST);
  assign bit_tick_next = (count_q == CNT_PRE) && !clr;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per valid/ready handshake as an 8N1 frame.
// tx and tx_done are registered; tx is computed from the next state so it lines up with it.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_tx_state_e       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 timer_clr;
  logic                 bit_tick;
  logic                 bit_tick_next;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .clr          (timer_clr),
    .bit_tick     (bit_tick),
    .bit_tick_next(bit_tick_next)
  );

  // Next-state, shift register and registered-output decode.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
          state_d = START;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The timer restarts on every state entry and is held at zero in IDLE.
    timer_clr = (state_q == IDLE) || (state_d != state_q);

    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase

    done_d = (state_q == STOP) && bit_tick_next;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=8: frame shape, timing, handshake and reset behaviour.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int n_vec;
  int n_miss;

  uart_tx dut (
    .clk     (clk),
    .reset   (reset),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer a byte at the current negedge, then sample each of the 80 frame cycles.
  // exp holds the hand-computed line bits in time order (bit 0 = start bit).
  task automatic run_frame(input logic [7:0] b, input logic [9:0] exp,
                           input logic [7:0] next_data, input bit keep_valid, input bit inject);
    logic [9:0] obs;
    int glitch;
    int busy_n;
    int done_n;
    int done_at;
    obs = '0; glitch = 0; busy_n = 0; done_n = 0; done_at = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    chk("ready_pre", tx_ready, 1);
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        tx_data = next_data;
        if (!keep_valid) tx_valid = 1'b0;
        chk("start_lat", tx, 0);
      end
      if (inject && k == 20) begin
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        chk("ready_busy", tx_ready, 0);
      end
      if (inject && k == 21) tx_valid = 1'b0;
      if ((k - 1) % 8 == 4) obs[(k - 1) / 8] = tx;
      if (tx !== exp[(k - 1) / 8]) glitch++;
      if (busy === 1'b1) busy_n++;
      if (tx_done === 1'b1) begin
        done_n++;
        done_at = k;
      end
    end
    chk("frame", obs, exp);
    chk("bit_glitch", glitch, 0);
    chk("busy_cnt", busy_n, 80);
    chk("done_cnt", done_n, 1);
    chk("done_at", done_at, 80);
  endtask

  // The single IDLE cycle after a frame: line high and ready.
  task automatic idle_one();
    @(posedge clk);
    @(negedge clk);
    chk("gap_tx", tx, 1);
    chk("gap_ready", tx_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] lb_data [4];
    logic [9:0] lb_exp  [4];
    int cnt;
    lb_data = '{8'h00, 8'h55, 8'hAA, 8'hFF};
    lb_exp  = '{10'h200, 10'h2AA, 10'h354, 10'h3FE};
    n_vec = 0; n_miss = 0;
    reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);

    reset = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx === 1'b1 && busy === 1'b0) cnt++;
    end
    chk("idle_high", cnt, 50);

    // Single byte 0xA5: 0,1,0,1,0,0,1,0,1,1.
    run_frame(8'hA5, 10'h34A, 8'h5A, 1'b0, 1'b0);
    idle_one();

    // Back-to-back 0x00 then 0xFF with tx_valid held through the frame.
    run_frame(8'h00, 10'h200, 8'hFF, 1'b1, 1'b0);
    idle_one();
    run_frame(8'hFF, 10'h3FE, 8'h00, 1'b0, 1'b0);
    idle_one();

    // 0x3C offered mid-frame must be dropped.
    run_frame(8'h81, 10'h302, 8'h3C, 1'b0, 1'b1);
    idle_one();
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) cnt++;
    end
    chk("no_second", cnt, 0);

    // Reset during data bit 3 of 0x00 (frame cycles 33..40).
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (35) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_tx", tx, 0);
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("mrst_tx", tx, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", tx_ready, 1);
    chk("mrst_done", tx_done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame(8'h5A, 10'h2B4, 8'h00, 1'b0, 1'b0);
    idle_one();

    // Center-sampled decode of the receiver's test bytes.
    for (int i = 0; i < 4; i++) begin
      run_frame(lb_data[i], lb_exp[i], 8'hC3, 1'b0, 1'b0);
      idle_one();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: the transmit end of the serial link whose receive end is rx_datapath.
- Accepts one byte per valid/ready handshake and serialises it as an 8N1 frame on `tx`: start bit (0), 8 data bits LSB first, stop bit (1).
- Bit period is a fixed number of clk cycles, so the frame is sampled correctly by the 8x-oversampling receiver.
- Sits between the processor's memory-mapped UART register block and the `tx` pad.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per serial bit; legal range is 2 or more; matches the receiver sample counter period.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this link.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- tx_valid  input  1  a byte is offered on tx_data
- tx_data  input  8  byte to send; sampled only at handshake
- tx_ready  output  1  block can accept a byte; high only in IDLE
- tx  output  1  serial line, registered; idles high
- busy  output  1  a frame is in progress (any state except IDLE)
- tx_done  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, tx=1, busy=0, tx_done=0, tx_ready=1.
  - Bit timer=0, bit index=0, shift register=0.
  - Takes effect immediately mid-frame; the line returns high with no stop bit. The receiver handles this as a framing error.
- States are IDLE, START, DATA, STOP.
  - IDLE: tx=1. When tx_valid&&tx_ready at a rising edge: latch tx_data into the shift register, clear the bit timer, go to START. tx=0 from the next cycle.
  - START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. At each bit boundary, shift right by one and increment the index. After bit index DATA_BITS-1 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. tx_done=1 on the last of these cycles, then go to IDLE.
- Bit timer:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1. The terminal count produces an internal bit_tick and wraps to 0.
  - Cleared on every state entry; never free-runs in IDLE.
- Timing:
  - Handshake to first start-bit cycle: 1 cycle.
  - Frame length: exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back with tx_valid held high: IDLE lasts exactly 1 cycle. The line therefore stays high for CLKS_PER_BIT+1 cycles between frames.
  - Maximum throughput: one byte per 10*CLKS_PER_BIT+1 cycles.
- Handshake rules:
  - tx_ready=(state==IDLE), combinational from the state register.
  - tx_valid while busy is ignored; no queueing.
  - tx_data changes during a frame do not affect the frame in flight.
- Simultaneous events:
  - tx_done and the next handshake never share a cycle, because tx_ready=0 in STOP.
  - reset overrides all other inputs.
- Outputs tx and tx_done are registered. busy and tx_ready are decoded from state.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_e
  - localparam UART_DATA_BITS=8
  - localparam UART_CLKS_PER_BIT=8
  - The receiver shares this package for the frame constants.
- One sub-module, tx_bit_timer:
  - Inputs: clk, reset, clr.
  - Output: bit_tick.
  - Parameterised by CLKS_PER_BIT.
- The FSM and the parallel-in/serial-out shift register stay in uart_tx.

Test Plan:
- Reset value check: assert reset=0 -> tx=1, tx_ready=1, busy=0, tx_done=0. Deassert reset and idle 50 cycles -> tx stays 1.
- Single byte (CLKS_PER_BIT=8): send 0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles. busy high for 80 cycles. tx_done pulses once at cycle 80 after the handshake.
- Back-to-back: send 0x00 then 0xFF with tx_valid held -> second start bit begins exactly 1 cycle after the first frame's tx_done. The inter-frame high period is 9 cycles.
- Ignore while busy: pulse tx_valid with 0x3C at cycle 20 of a 0x81 frame -> tx_ready=0 and the frame still carries 0x81. No second frame follows.
- Mid-frame reset: assert reset during data bit 3 -> tx=1 and state=IDLE in the same cycle. After release, a fresh 0x5A frame transmits correctly.
- Loopback: drive tx into rx_datapath's input and send 0x00, 0x55, 0xAA, 0xFF -> each byte appears on the receiver's data_out with its stop indication asserted.
